// File: rtl/regif_sync_fifo_pkg.sv
// Shared defaults for the register-interface FIFO: geometry and threshold defaults.
package regif_sync_fifo_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_PTR       = 4;
  localparam int DEF_AFULL_TH  = 14;
  localparam int DEF_AEMPTY_TH = 1;
  localparam int DEF_FWFT      = 0;

  // True when depth is a power of two matching the pointer width and at least 2.
  function automatic bit geometry_ok(input int depth, input int ptr);
    return (depth >= 2) && (depth == (1 << ptr));
  endfunction

endpackage

// File: rtl/regif_fifo_ram.sv
// Register array with one synchronous write port and one asynchronous read port.
module regif_fifo_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/regif_sync_fifo.sv
// Single-clock FIFO, registered (1-cycle) or show-ahead read; writes when full and
// reads when empty are dropped and latched into sticky overflow/underflow flags.
module regif_sync_fifo
  import regif_sync_fifo_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int PTR       = DEF_PTR,
  parameter int AFULL_TH  = DEF_AFULL_TH,
  parameter int AEMPTY_TH = DEF_AEMPTY_TH,
  parameter int FWFT      = DEF_FWFT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wren,
  input  logic [WIDTH-1:0] datain,
  input  logic             rden,
  output logic [WIDTH-1:0] dataout,
  output logic             full,
  output logic             empty,
  output logic             afull,
  output logic             aempty,
  output logic [PTR:0]     usedw,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  if (!geometry_ok(DEPTH, PTR)) begin : g_bad_geometry
    $error("regif_sync_fifo: DEPTH must equal 2**PTR and be >= 2");
  end
  if (AFULL_TH < 1 || AFULL_TH > DEPTH) begin : g_bad_afull
    $error("regif_sync_fifo: AFULL_TH out of range 1..DEPTH");
  end
  if (AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_bad_aempty
    $error("regif_sync_fifo: AEMPTY_TH out of range 0..DEPTH-1");
  end

  localparam logic [PTR:0] ONE      = (PTR+1)'(1);
  localparam logic [PTR:0] DEPTH_W  = (PTR+1)'(DEPTH);
  localparam logic [PTR:0] AFULL_W  = (PTR+1)'(AFULL_TH);
  localparam logic [PTR:0] AEMPTY_W = (PTR+1)'(AEMPTY_TH);

  logic [PTR:0]     wptr, rptr, usedw_nxt;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] rd_data;

  assign wr_acc = wren && !full;
  assign rd_acc = rden && !empty;

  always_comb begin
    usedw_nxt = usedw;
    if (wr_acc && !rd_acc)      usedw_nxt = usedw + ONE;
    else if (rd_acc && !wr_acc) usedw_nxt = usedw - ONE;
  end

  regif_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr[PTR-1:0]),
    .wdata (datain),
    .raddr (rptr[PTR-1:0]),
    .rdata (rd_data)
  );

  // Flags come from the next occupancy so they line up with the edge that changes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      usedw     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      afull     <= 1'b0;
      aempty    <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wptr <= wptr + ONE;
      if (rd_acc) rptr <= rptr + ONE;
      usedw     <= usedw_nxt;
      full      <= (usedw_nxt == DEPTH_W);
      empty     <= (usedw_nxt == '0);
      afull     <= (usedw_nxt >= AFULL_W);
      aempty    <= (usedw_nxt <= AEMPTY_W);
      overflow  <= (overflow  && !clr_err) || (wren && full);
      underflow <= (underflow && !clr_err) || (rden && empty);
    end
  end

  if (FWFT != 0) begin : g_show_ahead
    assign dataout = empty ? '0 : rd_data;
  end else begin : g_registered
    always_ff @(posedge clk) begin
      if (reset)       dataout <= '0;
      else if (rd_acc) dataout <= rd_data;
    end
  end

endmodule

// File: tb/tb_regif_sync_fifo.sv
// Drives a registered-read and a show-ahead FIFO with identical stimulus and checks
// both against a queue-based reference model.
module tb_regif_sync_fifo;

  localparam int W = 32;
  localparam int D = 16;

  logic          clk = 1'b0;
  logic          reset, wren, rden, clr_err;
  logic [W-1:0]  datain;

  logic [W-1:0]  dout0, dout1;
  logic          full0, empty0, afull0, aempty0, ovf0, unf0;
  logic          full1, empty1, afull1, aempty1, ovf1, unf1;
  logic [4:0]    usedw0, usedw1;

  always #5 clk = ~clk;

  regif_sync_fifo #(.FWFT(0)) u_reg (
    .clk(clk), .reset(reset), .wren(wren), .datain(datain), .rden(rden),
    .dataout(dout0), .full(full0), .empty(empty0), .afull(afull0), .aempty(aempty0),
    .usedw(usedw0), .overflow(ovf0), .underflow(unf0), .clr_err(clr_err)
  );

  regif_sync_fifo #(.FWFT(1)) u_fwft (
    .clk(clk), .reset(reset), .wren(wren), .datain(datain), .rden(rden),
    .dataout(dout1), .full(full1), .empty(empty1), .afull(afull1), .aempty(aempty1),
    .usedw(usedw1), .overflow(ovf1), .underflow(unf1), .clr_err(clr_err)
  );

  // Reference model state
  logic [W-1:0] q[$];
  logic [W-1:0] m_dout0;
  bit           m_ovf, m_unf;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("usedw0",  usedw0,  n);
    chk("usedw1",  usedw1,  n);
    chk("full0",   full0,   n == D);
    chk("full1",   full1,   n == D);
    chk("empty0",  empty0,  n == 0);
    chk("empty1",  empty1,  n == 0);
    chk("afull0",  afull0,  n >= 14);
    chk("afull1",  afull1,  n >= 14);
    chk("aempty0", aempty0, n <= 1);
    chk("aempty1", aempty1, n <= 1);
    chk("ovf0",    ovf0,    m_ovf);
    chk("ovf1",    ovf1,    m_ovf);
    chk("unf0",    unf0,    m_unf);
    chk("unf1",    unf1,    m_unf);
    chk("dout_reg",  dout0, m_dout0);
    chk("dout_fwft", dout1, (n == 0) ? 32'h0 : q[0]);
  endtask

  // One clock: drive inputs in the low phase, advance the model, check after the falling edge.
  task automatic step(input bit w, input logic [W-1:0] d, input bit r, input bit c, input bit rst);
    bit was_full, was_empty;
    reset = rst; wren = w; datain = d; rden = r; clr_err = c;
    if (rst) begin
      q.delete();
      m_dout0 = '0;
      m_ovf = 0;
      m_unf = 0;
    end else begin
      was_full  = (q.size() == D);
      was_empty = (q.size() == 0);
      if (r && !was_empty) m_dout0 = q.pop_front();
      if (w && !was_full)  q.push_back(d);
      m_ovf = (m_ovf && !c) || (w && was_full);
      m_unf = (m_unf && !c) || (r && was_empty);
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic fill_to(input int n);
    while (q.size() < n) step(1, $urandom, 0, 0, 0);
    while (q.size() > n) step(0, '0, 1, 0, 0);
  endtask

  initial begin
    logic [W-1:0] first_word;
    reset = 1'b1; wren = 0; rden = 0; clr_err = 0; datain = '0;
    q.delete(); m_dout0 = '0; m_ovf = 0; m_unf = 0;

    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    chk("rst_usedw", usedw0, 0);
    chk("rst_empty", empty0, 1);

    // Fill with a recognisable ramp
    for (int i = 0; i < D; i++) step(1, 32'h1000 + i, 0, 0, 0);
    chk("fill_full", full0, 1);

    // Overflow write, then drain in order
    step(1, 32'hDEAD, 0, 0, 0);
    chk("ovf_usedw", usedw0, 16);
    for (int i = 0; i < D; i++) begin
      step(0, '0, 1, 0, 0);
      chk("drain_order", dout0, 32'h1000 + i);
    end
    step(0, '0, 0, 1, 0);
    chk("ovf_cleared", ovf0, 0);

    // Underflow; clear coinciding with a new empty read keeps the flag
    step(0, '0, 1, 0, 0);
    step(0, '0, 1, 1, 0);
    chk("unf_set_wins", unf0, 1);
    step(0, '0, 0, 1, 0);

    // Simultaneous read and write at full, empty and mid-level
    fill_to(16);
    step(1, 32'hBEEF, 1, 0, 0);
    chk("rw_full_usedw", usedw0, 15);
    fill_to(0);
    step(1, 32'hCAFE, 1, 0, 0);
    chk("rw_empty_usedw", usedw0, 1);
    fill_to(5);
    step(1, 32'h5555, 1, 0, 0);
    chk("rw_mid_usedw", usedw0, 5);
    step(0, '0, 0, 1, 0);

    // Random traffic across several pointer wraps
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 99) < 55, $urandom, $urandom_range(0, 99) < 50,
           $urandom_range(0, 15) == 0, 0);

    // Reset mid-operation discards stored words
    fill_to(7);
    step(0, '0, 0, 0, 1);
    chk("midrst_usedw", usedw0, 0);
    first_word = $urandom;
    step(1, first_word, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    chk("post_rst_word", dout0, first_word);

    // Show-ahead: word visible without a read, gone after the pop
    step(1, 32'hA5A5A5A5, 0, 0, 0);
    chk("fwft_head", dout1, 32'hA5A5A5A5);
    step(0, '0, 1, 0, 0);
    chk("fwft_empty", empty1, 1);
    chk("fwft_zero", dout1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
